// File: rtl/uart_autobaud.sv
// Auto-baud calibrator: times four bit-pairs of a 0x55 sync character and derives the receiver divider.
// States: IDLE (rx enabled) | ARM (wait line high) | SEEK (wait start edge) | MEASURE (time edges 1..5) | SETTLE (wait stop bit)
module uart_autobaud #(
  parameter int DEFAULT_DIVIDER = 433,
  parameter int MIN_DIVIDER     = 4,
  parameter int TIMEOUT_CYCLES  = 8191
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       cal_start,
  input  logic       cfg_we,
  input  logic [9:0] cfg_divider,
  output logic [9:0] divider,
  output logic       uart_rx_en,
  output logic       busy,
  output logic       locked,
  output logic       cal_error
);

  typedef enum logic [2:0] {IDLE, ARM, SEEK, MEASURE, SETTLE} state_t;

  localparam logic [9:0]  RESET_DIV  = 10'(DEFAULT_DIVIDER);
  localparam logic [13:0] MIN_PERIOD = 14'(MIN_DIVIDER + 1);
  localparam logic [13:0] MAX_PERIOD = 14'd1024;
  localparam logic [12:0] TIMEOUT    = 13'(TIMEOUT_CYCLES);

  state_t      state;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [12:0] count;
  logic [2:0]  edge_cnt;
  logic        fall;
  logic [13:0] period;
  logic        period_ok;

  assign fall      = rxd_prev & ~rxd_sync;
  // Rounded C/8: C spans eight bit times of 0x55.
  assign period    = ({1'b0, count} + 14'd4) >> 3;
  assign period_ok = (period >= MIN_PERIOD) && (period <= MAX_PERIOD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      divider    <= RESET_DIV;
      uart_rx_en <= 1'b1;
      busy       <= 1'b0;
      locked     <= 1'b0;
      cal_error  <= 1'b0;
      count      <= '0;
      edge_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          count    <= '0;
          edge_cnt <= '0;
          if (cfg_we) divider <= cfg_divider;
          if (cal_start) begin
            state      <= ARM;
            busy       <= 1'b1;
            uart_rx_en <= 1'b0;
            locked     <= 1'b0;
            cal_error  <= 1'b0;
          end
        end
        ARM: begin
          count <= '0;
          if (rxd_sync) state <= SEEK;
        end
        SEEK: begin
          if (fall) begin
            state    <= MEASURE;
            count    <= '0;
            edge_cnt <= 3'd1;
          end else if (count == TIMEOUT) begin
            state      <= IDLE;
            busy       <= 1'b0;
            uart_rx_en <= 1'b1;
            cal_error  <= 1'b1;
          end else begin
            count <= count + 13'd1;
          end
        end
        MEASURE: begin
          if (fall && edge_cnt == 3'd4) begin
            edge_cnt <= 3'd5;
            if (period_ok) begin
              divider <= period[9:0] - 10'd1;
              state   <= SETTLE;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              uart_rx_en <= 1'b1;
              cal_error  <= 1'b1;
            end
          end else if (count == TIMEOUT) begin
            state      <= IDLE;
            busy       <= 1'b0;
            uart_rx_en <= 1'b1;
            cal_error  <= 1'b1;
          end else begin
            count <= count + 13'd1;
            if (fall) edge_cnt <= edge_cnt + 3'd1;
          end
        end
        SETTLE: begin
          // Receiver stays off until the stop bit of the sync character is seen.
          if (rxd_sync) begin
            state      <= IDLE;
            busy       <= 1'b0;
            uart_rx_en <= 1'b1;
            locked     <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          uart_rx_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync characters at several bit rates, error paths and reset.
module tb_uart_autobaud;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       cal_start = 1'b0;
  logic       cfg_we = 1'b0;
  logic [9:0] cfg_divider = '0;
  logic [9:0] divider;
  logic       uart_rx_en, busy, locked, cal_error;

  int passed = 0;
  int total  = 0;

  logic [9:0] frame = 10'b1010101010;
  int jt[10] = '{2, -2, 1, -1, 0, 2, -2, 1, -1, 0};

  uart_autobaud dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .cal_start(cal_start),
    .cfg_we(cfg_we), .cfg_divider(cfg_divider), .divider(divider),
    .uart_rx_en(uart_rx_en), .busy(busy), .locked(locked), .cal_error(cal_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_bits(input int from, input int to, input int per, input bit jit);
    for (int i = from; i <= to; i++) begin
      uart_rxd = frame[i];
      repeat (per + (jit ? jt[i] : 0)) tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy === 1'b1; i++) tick();
    chk(tag, busy, 0);
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_divider", divider, 433);
    chk("rst_rx_en", uart_rx_en, 1);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    tick();
    chk("idle_locked", locked, 0);
    chk("idle_error", cal_error, 0);

    // Software write in IDLE
    cfg_divider = 10'd216; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("cfg_idle_div", divider, 216);
    chk("cfg_idle_locked", locked, 0);

    // 434 cycles/bit, C = 3472 -> 433
    start_cal();
    chk("cal434_busy", busy, 1);
    chk("cal434_rx_off", uart_rx_en, 0);
    send_bits(0, 3, 434, 1'b0);
    cfg_divider = 10'd300; cfg_we = 1'b1; cal_start = 1'b1;
    tick();
    cfg_we = 1'b0; cal_start = 1'b0;
    chk("cfg_busy_ignored", divider, 216);
    chk("cal434_still_busy", busy, 1);
    send_bits(4, 7, 434, 1'b0);
    uart_rxd = 1'b0;
    repeat (433) tick();
    chk("cal434_div_latched", divider, 433);
    chk("cal434_rx_off_last", uart_rx_en, 0);
    uart_rxd = 1'b1;
    wait_idle("cal434_done", 10);
    chk("cal434_locked", locked, 1);
    chk("cal434_rx_on", uart_rx_en, 1);
    chk("cal434_no_error", cal_error, 0);
    repeat (430) tick();

    // 87 cycles/bit with jitter, C = 697 -> 86
    start_cal();
    chk("cal87_locked_clr", locked, 0);
    send_bits(0, 9, 87, 1'b1);
    wait_idle("cal87_done", 10);
    chk("cal87_div", divider, 86);
    chk("cal87_locked", locked, 1);
    chk("cal87_no_error", cal_error, 0);

    // 3 cycles/bit -> candidate 2, rejected
    start_cal();
    send_bits(0, 9, 3, 1'b0);
    wait_idle("cal3_done", 10);
    chk("cal3_error", cal_error, 1);
    chk("cal3_div_kept", divider, 86);
    chk("cal3_locked", locked, 0);
    repeat (5) tick();

    // Line idle -> timeout
    start_cal();
    chk("to_error_clr", cal_error, 0);
    repeat (8000) tick();
    chk("to_busy_8000", busy, 1);
    wait_idle("to_done", 400);
    chk("to_error", cal_error, 1);
    chk("to_div_kept", divider, 86);
    chk("to_locked", locked, 0);
    chk("to_rx_on", uart_rx_en, 1);

    // cfg write and cal start together, then reset mid-MEASURE
    cfg_divider = 10'd100; cfg_we = 1'b1; cal_start = 1'b1;
    tick();
    cfg_we = 1'b0; cal_start = 1'b0;
    chk("both_div", divider, 100);
    chk("both_busy", busy, 1);
    tick();
    uart_rxd = 1'b0;
    repeat (20) tick();
    chk("meas_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_div", divider, 433);
    chk("arst_busy", busy, 0);
    chk("arst_rx_en", uart_rx_en, 1);
    chk("arst_locked", locked, 0);
    chk("arst_error", cal_error, 0);
    uart_rxd = 1'b1;
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_div", divider, 433);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
